// File: rtl/decode_pkg.sv
// Shared encodings for the decode stage: ROM op kinds, jump selects,
// sequencer state/kind types and the default slot counts per sequence.
package decode_pkg;

  localparam logic [2:0] OP_NORM = 3'd0;
  localparam logic [2:0] OP_CALL = 3'd1;
  localparam logic [2:0] OP_RET  = 3'd2;
  localparam logic [2:0] OP_RTI  = 3'd3;

  localparam logic [1:0] JS_NEXT   = 2'b00;
  localparam logic [1:0] JS_BRANCH = 2'b01;
  localparam logic [1:0] JS_MEM    = 2'b10;
  localparam logic [1:0] JS_VECTOR = 2'b11;

  localparam int DEF_CALL_CYC = 2;
  localparam int DEF_RET_CYC  = 3;
  localparam int DEF_RTI_CYC  = 3;
  localparam int DEF_INT_CYC  = 2;

  typedef enum logic {
    ST_IDLE,
    ST_SEQ
  } seq_state_e;

  typedef enum logic [1:0] {
    K_CALL,
    K_RET,
    K_RTI,
    K_INT
  } seq_kind_e;

  // Where the PC goes once a sequence (or its single slot) finishes.
  function automatic logic [1:0] kind_jump(input seq_kind_e k);
    case (k)
      K_CALL:  return JS_BRANCH;
      K_INT:   return JS_VECTOR;
      default: return JS_MEM;
    endcase
  endfunction

  function automatic logic is_seq_op(input logic [2:0] op);
    return (op == OP_CALL) || (op == OP_RET) || (op == OP_RTI);
  endfunction

  function automatic seq_kind_e op_to_kind(input logic [2:0] op);
    case (op)
      OP_CALL: return K_CALL;
      OP_RET:  return K_RET;
      default: return K_RTI;
    endcase
  endfunction

endpackage

// File: rtl/reg_file_bypass.sv
// NREG x W register file, two combinational read ports, one write port.
// A read of the address being written this cycle returns the write data.
module reg_file_bypass #(
  parameter int NREG = 8,
  parameter int W    = 16,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [W-1:0]  wd,
  input  logic [AW-1:0] ra0,
  input  logic [AW-1:0] ra1,
  output logic [W-1:0]  rd0,
  output logic [W-1:0]  rd1
);

  logic [W-1:0] regs [NREG];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we) begin
      regs[wa] <= wd;
    end
  end

  assign rd0 = (we && (wa == ra0)) ? wd : regs[ra0];
  assign rd1 = (we && (wa == ra1)) ? wd : regs[ra1];

endmodule

// File: rtl/decode_stage_seq.sv
// Decode stage: register file, stack pointer, load-use bubbles, and a
// sequencer that expands CALL/RET/RTI/interrupt entry into multi-slot runs.
module decode_stage_seq
  import decode_pkg::*;
#(
  parameter int W           = 16,
  parameter int NREG        = 8,
  parameter int AW          = $clog2(NREG),
  parameter int SP_W        = 16,
  parameter int STACK_START = 2**11 - 1,
  parameter int EX_W        = 14,
  parameter int MEM_W       = 7,
  parameter int WB_W        = 6,
  parameter int CALL_CYC    = DEF_CALL_CYC,
  parameter int RET_CYC     = DEF_RET_CYC,
  parameter int RTI_CYC     = DEF_RTI_CYC,
  parameter int INT_CYC     = DEF_INT_CYC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       op_kind,
  input  logic [EX_W-1:0]  ex_in,
  input  logic [MEM_W-1:0] mem_in,
  input  logic [WB_W-1:0]  wb_in,
  input  logic             mem_read_in,
  input  logic             wb_en_in,
  input  logic             uses_src,
  input  logic             uses_dst,
  input  logic [AW-1:0]    src,
  input  logic [AW-1:0]    dst,
  input  logic             reg_we,
  input  logic [AW-1:0]    wa,
  input  logic [W-1:0]     wd,
  input  logic             sp_we,
  input  logic [SP_W-1:0]  sp_wd,
  input  logic             interrupt,
  input  logic             branch_taken,
  output logic [EX_W-1:0]  ex_out,
  output logic [MEM_W-1:0] mem_out,
  output logic [WB_W-1:0]  wb_out,
  output logic [W-1:0]     rsrc,
  output logic [W-1:0]     rdst,
  output logic [SP_W-1:0]  sp,
  output logic             fd_enable,
  output logic             pc_enable,
  output logic             flush,
  output logic [1:0]       jump_sel,
  output logic             busy,
  output logic [2:0]       seq_step
);

  localparam logic [2:0] CALL_LAST = 3'(CALL_CYC - 1);
  localparam logic [2:0] RET_LAST  = 3'(RET_CYC - 1);
  localparam logic [2:0] RTI_LAST  = 3'(RTI_CYC - 1);
  localparam logic [2:0] INT_LAST  = 3'(INT_CYC - 1);

  function automatic logic [2:0] last_step(input seq_kind_e k);
    case (k)
      K_CALL:  return CALL_LAST;
      K_RET:   return RET_LAST;
      K_RTI:   return RTI_LAST;
      default: return INT_LAST;
    endcase
  endfunction

  seq_state_e    state, state_d;
  seq_kind_e     kind, kind_d;
  logic [2:0]    step, step_d;
  logic          int_pend;
  logic          prev_valid, prev_mem_read, prev_wb_en;
  logic [AW-1:0] prev_dst;
  logic          issue, int_take, stall;
  seq_kind_e     op_k;
  logic          op_seq;

  reg_file_bypass #(.NREG(NREG), .W(W), .AW(AW)) u_rf (
    .clk (clk),
    .rst (rst),
    .we  (reg_we),
    .wa  (wa),
    .wd  (wd),
    .ra0 (src),
    .ra1 (dst),
    .rd0 (rsrc),
    .rd1 (rdst)
  );

  assign op_seq   = is_seq_op(op_kind);
  assign op_k     = op_to_kind(op_kind);
  assign busy     = (state == ST_SEQ);
  assign seq_step = step;

  // Load-use: the previous slot loads into a register this one reads.
  assign stall = prev_valid & prev_mem_read & prev_wb_en &
                 ((uses_src & (src == prev_dst)) | (uses_dst & (dst == prev_dst)));

  always_comb begin
    ex_out    = '0;
    mem_out   = '0;
    wb_out    = '0;
    fd_enable = 1'b1;
    pc_enable = 1'b1;
    flush     = 1'b0;
    jump_sel  = JS_NEXT;
    issue     = 1'b0;
    int_take  = 1'b0;
    state_d   = state;
    kind_d    = kind;
    step_d    = step;

    if (branch_taken) begin
      flush    = 1'b1;
      jump_sel = JS_BRANCH;
      state_d  = ST_IDLE;
      step_d   = '0;
    end else if (state == ST_SEQ) begin
      issue     = 1'b1;
      fd_enable = 1'b0;
      pc_enable = 1'b0;
      if (step == last_step(kind)) begin
        fd_enable = 1'b1;
        pc_enable = 1'b1;
        jump_sel  = kind_jump(kind);
        state_d   = ST_IDLE;
        step_d    = '0;
      end else begin
        step_d = step + 3'd1;
      end
    end else if (stall) begin
      fd_enable = 1'b0;
      pc_enable = 1'b0;
    end else if (int_pend && (op_kind != OP_CALL)) begin
      int_take = 1'b1;
      if (INT_LAST != 3'd0) begin
        state_d = ST_SEQ;
        kind_d  = K_INT;
        step_d  = '0;
      end else begin
        issue    = 1'b1;
        jump_sel = JS_VECTOR;
      end
    end else if (op_seq && (last_step(op_k) != 3'd0)) begin
      state_d = ST_SEQ;
      kind_d  = op_k;
      step_d  = '0;
    end else begin
      // Single-slot instruction; a one-slot CALL/RET/RTI jumps right away.
      issue = 1'b1;
      if (op_seq) jump_sel = kind_jump(op_k);
    end

    if (issue) begin
      ex_out  = ex_in;
      mem_out = mem_in;
      wb_out  = wb_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      kind          <= K_CALL;
      step          <= '0;
      int_pend      <= 1'b0;
      prev_valid    <= 1'b0;
      prev_mem_read <= 1'b0;
      prev_wb_en    <= 1'b0;
      prev_dst      <= '0;
    end else begin
      state <= state_d;
      kind  <= kind_d;
      step  <= step_d;
      // A new request in the cycle the INT run starts is kept pending.
      if (interrupt) int_pend <= 1'b1;
      else if (int_take) int_pend <= 1'b0;
      prev_valid <= issue;
      if (issue) begin
        prev_mem_read <= mem_read_in;
        prev_wb_en    <= wb_en_in;
        prev_dst      <= dst;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sp <= SP_W'(STACK_START);
    else if (sp_we) sp <= sp_wd;
  end

endmodule

// File: tb/tb_decode_stage_seq.sv
// Directed scenarios for decode_stage_seq with a per-cycle expected queue
// for the control/issue outputs and direct checks of read data and SP.
module tb_decode_stage_seq;
  import decode_pkg::*;

  localparam int W = 16, NREG = 8, AW = 3, SP_W = 16;
  localparam int EX_W = 14, MEM_W = 7, WB_W = 6;
  localparam int CW = EX_W + MEM_W + WB_W + 9;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [2:0]       op_kind;
  logic [EX_W-1:0]  ex_in;
  logic [MEM_W-1:0] mem_in;
  logic [WB_W-1:0]  wb_in;
  logic             mem_read_in, wb_en_in, uses_src, uses_dst;
  logic [AW-1:0]    src, dst, wa;
  logic             reg_we, sp_we, interrupt, branch_taken;
  logic [W-1:0]     wd;
  logic [SP_W-1:0]  sp_wd;
  logic [EX_W-1:0]  ex_out;
  logic [MEM_W-1:0] mem_out;
  logic [WB_W-1:0]  wb_out;
  logic [W-1:0]     rsrc, rdst;
  logic [SP_W-1:0]  sp;
  logic             fd_enable, pc_enable, flush, busy;
  logic [1:0]       jump_sel;
  logic [2:0]       seq_step;

  int total = 0;
  int bad   = 0;
  logic [CW-1:0] exp_q[$];
  string         tag_q[$];

  always #5 clk = ~clk;

  decode_stage_seq #(
    .W(W), .NREG(NREG), .SP_W(SP_W), .STACK_START(2**11 - 1),
    .EX_W(EX_W), .MEM_W(MEM_W), .WB_W(WB_W),
    .CALL_CYC(2), .RET_CYC(3), .RTI_CYC(3), .INT_CYC(2)
  ) dut (
    .clk(clk), .rst(rst), .op_kind(op_kind),
    .ex_in(ex_in), .mem_in(mem_in), .wb_in(wb_in),
    .mem_read_in(mem_read_in), .wb_en_in(wb_en_in),
    .uses_src(uses_src), .uses_dst(uses_dst), .src(src), .dst(dst),
    .reg_we(reg_we), .wa(wa), .wd(wd), .sp_we(sp_we), .sp_wd(sp_wd),
    .interrupt(interrupt), .branch_taken(branch_taken),
    .ex_out(ex_out), .mem_out(mem_out), .wb_out(wb_out),
    .rsrc(rsrc), .rdst(rdst), .sp(sp),
    .fd_enable(fd_enable), .pc_enable(pc_enable), .flush(flush),
    .jump_sel(jump_sel), .busy(busy), .seq_step(seq_step)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [CW-1:0] obs_ctl();
    return {ex_out, mem_out, wb_out, fd_enable, pc_enable, flush, jump_sel, busy, seq_step};
  endfunction

  // Expected vector when the current control words are issued.
  function automatic logic [CW-1:0] e_issue(input logic fd, input logic pc,
                                            input logic [1:0] js, input logic bz,
                                            input logic [2:0] st);
    return {ex_in, mem_in, wb_in, fd, pc, 1'b0, js, bz, st};
  endfunction

  function automatic logic [CW-1:0] e_bubble(input logic fd, input logic pc, input logic fl,
                                             input logic [1:0] js, input logic bz,
                                             input logic [2:0] st);
    return {{(EX_W + MEM_W + WB_W){1'b0}}, fd, pc, fl, js, bz, st};
  endfunction

  task automatic neutral();
    op_kind      = OP_NORM;
    ex_in        = EX_W'($urandom_range(1, (1 << EX_W) - 1));
    mem_in       = MEM_W'($urandom_range(0, (1 << MEM_W) - 1));
    wb_in        = WB_W'($urandom_range(0, (1 << WB_W) - 1));
    mem_read_in  = 1'b0;
    wb_en_in     = 1'b0;
    uses_src     = 1'b0;
    uses_dst     = 1'b0;
    src          = '0;
    dst          = '0;
    reg_we       = 1'b0;
    wa           = '0;
    wd           = '0;
    sp_we        = 1'b0;
    sp_wd        = '0;
    interrupt    = 1'b0;
    branch_taken = 1'b0;
  endtask

  // One clock: queue the expectation, compare at the falling edge, advance.
  task automatic cyc(input string tag, input logic [CW-1:0] e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    chk(tag_q.pop_front(), 64'(obs_ctl()), 64'(exp_q.pop_front()));
    @(posedge clk);
    #1;
    neutral();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    neutral();
    ex_in = '0; mem_in = '0; wb_in = '0;
    @(negedge clk);
    chk("rst_ctl", 64'(obs_ctl()), 64'(e_bubble(1, 1, 0, JS_NEXT, 0, 0)));
    chk("rst_sp", 64'(sp), 64'h07FF);
    @(posedge clk);
    #1;
    rst = 1'b0;
    neutral();

    for (int i = 0; i < 3; i++) cyc("norm", e_issue(1, 1, JS_NEXT, 0, 0));
    op_kind = 3'd5;
    cyc("op5_norm", e_issue(1, 1, JS_NEXT, 0, 0));
    branch_taken = 1'b1;
    cyc("br_idle", e_bubble(1, 1, 1, JS_BRANCH, 0, 0));

    sp_we = 1'b1; sp_wd = 16'h07FD;
    chk("sp_before", 64'(sp), 64'h07FF);
    cyc("sp_ld", e_issue(1, 1, JS_NEXT, 0, 0));
    chk("sp_after", 64'(sp), 64'h07FD);

    reg_we = 1'b1; wa = 3'd2; wd = 16'hBEEF; src = 3'd2; dst = 3'd5;
    #1;
    chk("bypass_r2", 64'(rsrc), 64'hBEEF);
    chk("r5_zero", 64'(rdst), 64'h0);
    cyc("wr_r2", e_issue(1, 1, JS_NEXT, 0, 0));
    reg_we = 1'b1; wa = 3'd0; wd = 16'h0042; src = 3'd2; dst = 3'd0;
    #1;
    chk("r2_held", 64'(rsrc), 64'hBEEF);
    chk("bypass_r0", 64'(rdst), 64'h0042);
    cyc("wr_r0", e_issue(1, 1, JS_NEXT, 0, 0));
    src = 3'd0; dst = 3'd2;
    #1;
    chk("r0_read", 64'(rsrc), 64'h0042);
    chk("r2_read", 64'(rdst), 64'hBEEF);
    cyc("rd_only", e_issue(1, 1, JS_NEXT, 0, 0));

    mem_read_in = 1'b1; wb_en_in = 1'b1; dst = 3'd3;
    cyc("load_r3", e_issue(1, 1, JS_NEXT, 0, 0));
    uses_src = 1'b1; src = 3'd3; wb_en_in = 1'b1; dst = 3'd1;
    cyc("lu_stall", e_bubble(0, 0, 0, JS_NEXT, 0, 0));
    uses_src = 1'b1; src = 3'd3; wb_en_in = 1'b1; dst = 3'd1;
    cyc("lu_issue", e_issue(1, 1, JS_NEXT, 0, 0));
    mem_read_in = 1'b1; wb_en_in = 1'b1; dst = 3'd5;
    cyc("load_r5", e_issue(1, 1, JS_NEXT, 0, 0));
    uses_dst = 1'b1; dst = 3'd5;
    cyc("lu_dst_stall", e_bubble(0, 0, 0, JS_NEXT, 0, 0));
    uses_dst = 1'b1; dst = 3'd5;
    cyc("lu_dst_issue", e_issue(1, 1, JS_NEXT, 0, 0));
    mem_read_in = 1'b1; wb_en_in = 1'b1; dst = 3'd6;
    cyc("load_r6", e_issue(1, 1, JS_NEXT, 0, 0));
    src = 3'd6; uses_src = 1'b0; uses_dst = 1'b1; dst = 3'd1;
    cyc("no_use_no_stall", e_issue(1, 1, JS_NEXT, 0, 0));
    mem_read_in = 1'b1; wb_en_in = 1'b0; dst = 3'd3;
    cyc("load_nowb", e_issue(1, 1, JS_NEXT, 0, 0));
    uses_src = 1'b1; src = 3'd3;
    cyc("nowb_no_stall", e_issue(1, 1, JS_NEXT, 0, 0));

    op_kind = OP_RET;
    cyc("ret_launch", e_bubble(1, 1, 0, JS_NEXT, 0, 0));
    op_kind = OP_RET;
    cyc("ret_s0", e_issue(0, 0, JS_NEXT, 1, 0));
    cyc("ret_s1", e_issue(0, 0, JS_NEXT, 1, 1));
    cyc("ret_s2", e_issue(1, 1, JS_MEM, 1, 2));
    cyc("ret_after", e_issue(1, 1, JS_NEXT, 0, 0));

    op_kind = OP_CALL;
    cyc("call_launch", e_bubble(1, 1, 0, JS_NEXT, 0, 0));
    interrupt = 1'b1;
    cyc("call_s0", e_issue(0, 0, JS_NEXT, 1, 0));
    cyc("call_s1", e_issue(1, 1, JS_BRANCH, 1, 1));
    cyc("int_launch", e_bubble(1, 1, 0, JS_NEXT, 0, 0));
    cyc("int_s0", e_issue(0, 0, JS_NEXT, 1, 0));
    cyc("int_s1", e_issue(1, 1, JS_VECTOR, 1, 1));
    cyc("int_done", e_issue(1, 1, JS_NEXT, 0, 0));

    op_kind = OP_RTI; interrupt = 1'b1;
    cyc("rti_launch", e_bubble(1, 1, 0, JS_NEXT, 0, 0));
    cyc("rti_s0", e_issue(0, 0, JS_NEXT, 1, 0));
    branch_taken = 1'b1;
    cyc("rti_br", e_bubble(1, 1, 1, JS_BRANCH, 1, 1));
    cyc("rti_int_launch", e_bubble(1, 1, 0, JS_NEXT, 0, 0));
    cyc("rti_int_s0", e_issue(0, 0, JS_NEXT, 1, 0));
    cyc("rti_int_s1", e_issue(1, 1, JS_VECTOR, 1, 1));

    op_kind = OP_RET;
    cyc("rr_launch", e_bubble(1, 1, 0, JS_NEXT, 0, 0));
    interrupt = 1'b1;
    cyc("rr_s0", e_issue(0, 0, JS_NEXT, 1, 0));
    cyc("rr_s1", e_issue(0, 0, JS_NEXT, 1, 1));
    ex_in = '0; mem_in = '0; wb_in = '0;
    rst = 1'b1;
    #1;
    chk("rr_busy", 64'(busy), 64'h0);
    chk("rr_step", 64'(seq_step), 64'h0);
    chk("rr_sp", 64'(sp), 64'h07FF);
    chk("rr_ctl", 64'(obs_ctl()), 64'(e_bubble(1, 1, 0, JS_NEXT, 0, 0)));
    @(posedge clk);
    #1;
    rst = 1'b0;
    neutral();
    cyc("rr_after", e_issue(1, 1, JS_NEXT, 0, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
